fifo_sync_flags: RTL



---
 rtl/fifo_sync_flags.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and registered one-cycle write-ack, read-valid and error pulses.
module fifo_sync_flags #(
    parameter int FIFO_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 512,
    parameter int ADDRESS_SIZE = 9,
    parameter int AF_LEVEL     = 511,
    parameter int AE_LEVEL     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FIFO_WIDTH-1:0]   din,
    input  logic                    wen,
    input  logic                    ren,
    output logic [FIFO_WIDTH-1:0]   dout,
    output logic                    valid,
    output logic                    wr_ack,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    full,
    output logic                    empty,
    output logic                    almostfull,
    output logic                    almostempty,
    output logic [ADDRESS_SIZE:0]   count
);

    // Handshake: a request is taken on any edge where it is high; wen is accepted
    // unless full, ren unless empty. Each edge's outcome appears one cycle later
    // as exactly one of wr_ack/overflow (writes) and valid/underflow (reads).

    localparam logic [ADDRESS_SIZE:0] DEPTH_C = (ADDRESS_SIZE+1)'(FIFO_DEPTH);
    localparam logic [ADDRESS_SIZE:0] AF_C    = (ADDRESS_SIZE+1)'(AF_LEVEL);
    localparam logic [ADDRESS_SIZE:0] AE_C    = (ADDRESS_SIZE+1)'(AE_LEVEL);

    logic [FIFO_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic [FIFO_WIDTH-1:0]   dout_q, dout_d;
    logic                    valid_q, wr_ack_q, overflow_q, underflow_q;
    logic                    wr_acc, rd_acc;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= AF_C);
    assign almostempty = (count_q <= AE_C);

    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately left out of reset; only written words are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            valid_q     <= rd_acc;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wen && !wr_acc;
            underflow_q <= ren && !rd_acc;
        end
    end

    assign dout      = dout_q;
    assign valid     = valid_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign count     = count_q;

endmodule
